lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised LIFO return-address stack for the sequencer's subroutine/loop path; next generation of the fixed 5×12 µPC stack. Width and depth are parameters; it adds a replace-top operation, an empty flag, an occupancy count, and sticky overflow/underflow error flags. It sits between the µPC register and the next-address mux, and the instruction decoder drives its operation code.

## Interface
Parameters:
- WIDTH, 12, data word width in bits (≥1)
- DEPTH, 5, number of entries (≥2)
- CW, $clog2(DEPTH+1), count width (localparam, derived)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- op  input  3  operation: 000 HOLD, 001 PUSH, 010 POP, 011 CLEAR, 100 REPLACE; 101–111 reserved, behave as HOLD
- din  input  WIDTH  data for PUSH/REPLACE (µPC value)
- dout  output  WIDTH  top-of-stack word; all-zero when empty
- count  output  CW  number of valid entries, 0..DEPTH
- full_n  output  1  low when count == DEPTH
- empty_n  output  1  low when count == 0
- overflow  output  1  sticky: PUSH attempted while full
- underflow  output  1  sticky: POP or REPLACE attempted while empty

## Operation
- Storage: DEPTH×WIDTH register array plus pointer sp (= count). sp is the next free slot. TOS is mem[sp-1].
- HOLD: no state change.
- PUSH, not full: mem[sp] ← din, sp ← sp+1.
- PUSH, full: overflow ← 1. Data handling depends on STACK_OVERWRITE_EN (see Configuration). sp is unchanged.
- POP, not empty: sp ← sp−1. The popped entry's contents are not cleared.
- POP, empty: underflow ← 1, no other change.
- REPLACE, not empty: mem[sp-1] ← din, sp unchanged.
- REPLACE, empty: underflow ← 1, nothing written.
- CLEAR: sp ← 0, overflow ← 0, underflow ← 0. Array contents are don't-care.
- rst: same effect as CLEAR and has priority over any op in the same cycle.
- overflow and underflow stay set until rst or CLEAR. They are never cleared by a legal op.
- Reserved op codes: no state change, no flags set.
- dout, full_n, empty_n and count are combinational functions of sp and the array only. There is no path from op or din to any output.

## Timing
- One operation per clock, single cycle. Every op effect is visible on the outputs immediately after the edge that samples it.
- PUSH at edge N: dout == din(N), count+1 after edge N.
- POP at edge N: dout == previous-to-top entry after edge N, or 0 if the stack is now empty.
- Back-to-back PUSH/POP at full rate is required. Push-then-pop returns the pushed value.
- Reset values: dout = 0, count = 0, full_n = 1, empty_n = 0, overflow = 0, underflow = 0.
- rst asserted mid-sequence empties the stack on that edge. The op presented in the same cycle is discarded.
- Flags assert on the edge that samples the illegal op and are visible from the following cycle on.

## Configuration
- Macro: STACK_OVERWRITE_EN.
- Defined: PUSH while full writes din into mem[DEPTH-1], overwriting the TOS (Am2910-compatible), and dout becomes din. sp stays DEPTH and overflow is set.
- Undefined: PUSH while full is discarded, so array and dout are unchanged. overflow is set.
- Every other behaviour is identical in both builds.

## Test plan
- Reset, then idle: after rst for 1 cycle → count=0, dout=0, full_n=1, empty_n=0, overflow=0, underflow=0.
- Fill and drain (WIDTH=12, DEPTH=5): PUSH 0x101..0x105 on consecutive cycles → count=5, full_n=0, dout=0x105. Then 5 POPs → dout 0x104, 0x103, 0x102, 0x101, 0; empty_n=0 at the end; no flags set.
- Overflow: full with TOS 0x105, PUSH 0xABC → overflow=1, count=5. dout=0xABC with STACK_OVERWRITE_EN, 0x105 without. The next POP exposes 0x104 in both builds.
- Underflow and REPLACE: on an empty stack, POP then REPLACE 0x3F → underflow=1, count=0, dout=0. PUSH 0x010 then REPLACE 0x020 → dout=0x020, count=1, underflow still 1 until CLEAR.
- Reserved op and reset priority: op=111 on a stack with 3 entries → no change. PUSH 0x555 with rst=1 in the same cycle → count=0, dout=0, flags cleared.
- Parameter sweep: DEPTH=2/WIDTH=1 and DEPTH=16/WIDTH=32 random op stream vs. a reference-model queue → dout, count and flags match every cycle.

Source files
------------

// File: rtl/lifo_stack.sv
// Parametrised LIFO return-address stack with replace-top, occupancy count and sticky error flags.
// Build option STACK_OVERWRITE_EN: PUSH while full overwrites the top entry instead of being dropped.
module lifo_stack #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 5,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full_n,
    output logic             empty_n,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [2:0] OP_HOLD    = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_CLEAR   = 3'b011;
    localparam logic [2:0] OP_REPLACE = 3'b100;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_sp;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic [DEPTH-1:0] w_we;
    logic [WIDTH-1:0] w_dout;

    assign w_full  = (r_sp == CW'(DEPTH));
    assign w_empty = (r_sp == '0);

    // Per-entry write enables; rst suppresses any write requested in the same cycle.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (op)
                OP_PUSH: begin
                    if (!w_full && (r_sp == CW'(i)))
                        w_we[i] = 1'b1;
`ifdef STACK_OVERWRITE_EN
                    if (w_full && (i == DEPTH - 1))
                        w_we[i] = 1'b1;
`endif
                end
                OP_REPLACE: begin
                    if (r_sp == CW'(i + 1))
                        w_we[i] = 1'b1;
                end
                default: ;
            endcase
        end
        if (rst)
            w_we = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_we[i])
                r_mem[i] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (op)
                OP_HOLD: ;
                OP_PUSH: begin
                    if (w_full)
                        r_overflow <= 1'b1;
                    else
                        r_sp <= r_sp + CW'(1);
                end
                OP_POP: begin
                    if (w_empty)
                        r_underflow <= 1'b1;
                    else
                        r_sp <= r_sp - CW'(1);
                end
                OP_CLEAR: begin
                    r_sp        <= '0;
                    r_overflow  <= 1'b0;
                    r_underflow <= 1'b0;
                end
                OP_REPLACE: begin
                    if (w_empty)
                        r_underflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Top-of-stack select; reads as zero when the stack is empty.
    always_comb begin
        w_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_sp == CW'(i + 1))
                w_dout = r_mem[i];
        end
    end

    assign dout      = w_dout;
    assign count     = r_sp;
    assign full_n    = ~w_full;
    assign empty_n   = ~w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack plus a randomised sweep of two other geometries.
module tb_lifo_stack;

`ifdef STACK_OVERWRITE_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default geometry 12x5
    logic        rst;
    logic [2:0]  op;
    logic [11:0] din;
    logic [11:0] dout;
    logic [2:0]  count;
    logic        full_n, empty_n, overflow, underflow;
    logic [18:0] obs;
    logic [18:0] exp_v;
    assign obs = {count, dout, full_n, empty_n, overflow, underflow};

    lifo_stack #(.WIDTH(12), .DEPTH(5)) u_dut (
        .clk(clk), .rst(rst), .op(op), .din(din), .dout(dout), .count(count),
        .full_n(full_n), .empty_n(empty_n), .overflow(overflow), .underflow(underflow)
    );

    // small geometry 1x2
    logic        s_rst;
    logic [2:0]  s_op;
    logic [0:0]  s_din;
    logic [0:0]  s_dout;
    logic [1:0]  s_count;
    logic        s_full_n, s_empty_n, s_ovf, s_udf;

    lifo_stack #(.WIDTH(1), .DEPTH(2)) u_small (
        .clk(clk), .rst(s_rst), .op(s_op), .din(s_din), .dout(s_dout), .count(s_count),
        .full_n(s_full_n), .empty_n(s_empty_n), .overflow(s_ovf), .underflow(s_udf)
    );

    // large geometry 32x16
    logic        l_rst;
    logic [2:0]  l_op;
    logic [31:0] l_din;
    logic [31:0] l_dout;
    logic [4:0]  l_count;
    logic        l_full_n, l_empty_n, l_ovf, l_udf;

    lifo_stack #(.WIDTH(32), .DEPTH(16)) u_large (
        .clk(clk), .rst(l_rst), .op(l_op), .din(l_din), .dout(l_dout), .count(l_count),
        .full_n(l_full_n), .empty_n(l_empty_n), .overflow(l_ovf), .underflow(l_udf)
    );

    task automatic step(input logic r, input logic [2:0] o, input logic [11:0] d);
        rst = r; op = o; din = d;
        @(posedge clk);
        #1;
        rst = 1'b0; op = 3'b000;
    endtask

    task automatic test_reset();
        step(1'b1, 3'b001, 12'hFFF);
        exp_v = {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b000, 12'h123);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 3'b001, 12'h100 + 12'(i));
            exp_v = {3'(i), 12'h100 + 12'(i), (i != 5), 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL fill_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, 3'b010, 12'h0);
            exp_v = {3'(i), (i == 0) ? 12'h000 : 12'h100 + 12'(i), 1'b1, (i != 0), 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL drain_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) step(1'b0, 3'b001, 12'h100 + 12'(i));
        step(1'b0, 3'b001, 12'hABC);
        exp_v = {3'd5, OVR ? 12'hABC : 12'h105, 1'b0, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL overflow_push: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b010, 12'h0);
        exp_v = {3'd4, 12'h104, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL overflow_pop: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b011, 12'h0);
        exp_v = {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL overflow_clear: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_underflow_replace();
        step(1'b0, 3'b010, 12'h0);
        exp_v = {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL underflow_pop: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b100, 12'h03F);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL underflow_replace: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b001, 12'h010);
        exp_v = {3'd1, 12'h010, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL push_after_underflow: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b100, 12'h020);
        exp_v = {3'd1, 12'h020, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL replace_top: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b011, 12'h0);
        exp_v = {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL underflow_clear: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reserved_reset();
        step(1'b0, 3'b001, 12'h001);
        step(1'b0, 3'b001, 12'h002);
        step(1'b0, 3'b001, 12'h003);
        exp_v = {3'd3, 12'h003, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 5; c <= 8; c++) begin
            step(1'b0, (c == 8) ? 3'b000 : 3'(c), 12'h7FF);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reserved_op_%0d: got %h expected %h", c, obs, exp_v);
            end
        end
        step(1'b0, 3'b010, 12'h0);
        exp_v = {3'd2, 12'h002, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reserved_then_pop: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b010, 12'h0);
        step(1'b0, 3'b010, 12'h0);
        step(1'b0, 3'b010, 12'h0);
        step(1'b0, 3'b001, 12'h001);
        step(1'b1, 3'b001, 12'h555);
        exp_v = {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_priority: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 3'b001, 12'h0A1);
        step(1'b0, 3'b001, 12'h0B2);
        step(1'b0, 3'b010, 12'h0);
        exp_v = {3'd1, 12'h0A1, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_pop: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b001, 12'h0C3);
        exp_v = {3'd2, 12'h0C3, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_repush: got %h expected %h", obs, exp_v);
        end
        step(1'b0, 3'b010, 12'h0);
        step(1'b0, 3'b010, 12'h0);
        exp_v = {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_empty: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_sweep(input int depth, input int width, input int n);
        logic [31:0] m_mem [16];
        int          m_sp;
        logic        m_ovf, m_udf;
        logic [31:0] mask, d, exp_dout, got_dout;
        int          got_cnt;
        logic [3:0]  got_f, exp_f;
        logic        rs;
        logic [2:0]  o;
        int          r;
        mask  = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        m_sp  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int k = 0; k < 16; k++) m_mem[k] = '0;
        for (int t = 0; t < n; t++) begin
            rs = (t == 0) || ($urandom_range(0, 99) < 3);
            r  = $urandom_range(0, 99);
            if      (r < 35) o = 3'b001;
            else if (r < 65) o = 3'b010;
            else if (r < 70) o = 3'b011;
            else if (r < 85) o = 3'b100;
            else             o = 3'($urandom_range(0, 7));
            d = $urandom & mask;
            if (depth == 2) begin
                s_rst = rs; s_op = o; s_din = d[0:0];
            end else begin
                l_rst = rs; l_op = o; l_din = d;
            end
            @(posedge clk);
            #1;
            if (rs) begin
                m_sp = 0; m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                case (o)
                    3'b001: begin
                        if (m_sp < depth) begin
                            m_mem[m_sp] = d;
                            m_sp++;
                        end else begin
                            m_ovf = 1'b1;
                            if (OVR) m_mem[depth-1] = d;
                        end
                    end
                    3'b010: if (m_sp > 0) m_sp--; else m_udf = 1'b1;
                    3'b011: begin m_sp = 0; m_ovf = 1'b0; m_udf = 1'b0; end
                    3'b100: if (m_sp > 0) m_mem[m_sp-1] = d; else m_udf = 1'b1;
                    default: ;
                endcase
            end
            exp_dout = (m_sp == 0) ? 32'h0 : m_mem[m_sp-1];
            exp_f    = {(m_sp != depth), (m_sp != 0), m_ovf, m_udf};
            if (depth == 2) begin
                got_dout = {31'h0, s_dout};
                got_cnt  = int'(s_count);
                got_f    = {s_full_n, s_empty_n, s_ovf, s_udf};
            end else begin
                got_dout = l_dout;
                got_cnt  = int'(l_count);
                got_f    = {l_full_n, l_empty_n, l_ovf, l_udf};
            end
            checks++;
            if (got_dout !== exp_dout || got_cnt != m_sp || got_f !== exp_f) begin
                errors++;
                $display("FAIL sweep_d%0d_t%0d: got dout=%h cnt=%0d flags=%b expected dout=%h cnt=%0d flags=%b",
                         depth, t, got_dout, got_cnt, got_f, exp_dout, m_sp, exp_f);
            end
        end
        s_rst = 1'b0; s_op = 3'b000;
        l_rst = 1'b0; l_op = 3'b000;
    endtask

    initial begin
        rst = 1'b1; op = 3'b000; din = '0;
        s_rst = 1'b1; s_op = 3'b000; s_din = '0;
        l_rst = 1'b1; l_op = 3'b000; l_din = '0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_replace();
        test_reserved_reset();
        test_back_to_back();
        test_sweep(2, 1, 400);
        test_sweep(16, 32, 800);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
